// File: rtl/ddr3_axi_traffic_gen.sv
// ddr3_axi_traffic_gen: AXI4 write/read-back pattern generator and checker
// for exercising the ddr3_axi controller inport. Writes an address-derived
// pattern over a region in INCR bursts, reads it back, and counts errors.
module ddr3_axi_traffic_gen #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int unsigned NUM_BURSTS = 16,
  parameter int unsigned BURST_LEN  = 7,
  parameter logic [3:0]  AXI_ID     = 4'h3,
  parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  output logic        outport_bready_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  output logic        outport_rready_o,
  input  logic        outport_awready_i,
  input  logic        outport_wready_i,
  input  logic        outport_arready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  localparam logic [7:0]  LEN        = 8'(BURST_LEN);
  localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [31:0] STRIDE     = 32'((BURST_LEN + 1) * 4);

  state_t      state;
  logic [31:0] addr;
  logic [15:0] burst_cnt;
  logic [7:0]  beat_cnt;
  logic [7:0]  beat_next;
  logic [31:0] w_next_data;
  logic [31:0] r_expect;
  logic        b_hs;
  logic        r_hs;
  logic        last_burst;
  logic [2:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] err_next;

  // Beat addressing, handshake decode and saturating error accumulation
  always_comb begin
    beat_next   = beat_cnt + 8'd1;
    w_next_data = (addr + {22'b0, beat_next, 2'b00}) ^ SEED;
    r_expect    = (addr + {22'b0, beat_cnt, 2'b00}) ^ SEED;
    b_hs        = (state == ST_WR_RESP) && outport_bvalid_i && outport_bready_o;
    r_hs        = (state == ST_RD_DATA) && outport_rvalid_i && outport_rready_o;
    last_burst  = (burst_cnt == LAST_BURST);
    err_inc     = '0;
    if (b_hs)
      err_inc = {2'b0, outport_bresp_i != 2'b00}
              + {2'b0, outport_bid_i != AXI_ID};
    if (r_hs)
      err_inc = {2'b0, outport_rdata_i != r_expect}
              + {2'b0, outport_rresp_i != 2'b00}
              + {2'b0, outport_rid_i != AXI_ID}
              + {2'b0, outport_rlast_i != (beat_cnt == LEN)};
    err_sum  = {1'b0, err_count_o} + {14'b0, err_inc};
    err_next = err_sum[16] ? '1 : err_sum[15:0];
  end

  // Main sequencer; every output is a register updated here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= ST_IDLE;
      addr              <= '0;
      burst_cnt         <= '0;
      beat_cnt          <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      pass_o            <= 1'b0;
      err_count_o       <= '0;
      outport_awvalid_o <= 1'b0;
      outport_awaddr_o  <= '0;
      outport_awid_o    <= '0;
      outport_awlen_o   <= '0;
      outport_awburst_o <= '0;
      outport_wvalid_o  <= 1'b0;
      outport_wdata_o   <= '0;
      outport_wstrb_o   <= '0;
      outport_wlast_o   <= 1'b0;
      outport_bready_o  <= 1'b0;
      outport_arvalid_o <= 1'b0;
      outport_araddr_o  <= '0;
      outport_arid_o    <= '0;
      outport_arlen_o   <= '0;
      outport_arburst_o <= '0;
      outport_rready_o  <= 1'b0;
    end else begin
      err_count_o <= err_next;
      case (state)
        // done_o is raised on the final R handshake itself so it appears one
        // edge later; ST_DONE then lasts one cycle and accepts start like IDLE.
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start_i) begin
            busy_o            <= 1'b1;
            done_o            <= 1'b0;
            pass_o            <= 1'b0;
            err_count_o       <= '0;
            burst_cnt         <= '0;
            addr              <= ADDR_BASE;
            outport_awvalid_o <= 1'b1;
            outport_awaddr_o  <= ADDR_BASE;
            outport_awid_o    <= AXI_ID;
            outport_awlen_o   <= LEN;
            outport_awburst_o <= 2'b01;
            state             <= ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if (outport_awready_i) begin
            outport_awvalid_o <= 1'b0;
            outport_wvalid_o  <= 1'b1;
            outport_wdata_o   <= addr ^ SEED;
            outport_wstrb_o   <= '1;
            outport_wlast_o   <= (LEN == 8'd0);
            beat_cnt          <= '0;
            state             <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (outport_wready_i) begin
            if (outport_wlast_o) begin
              outport_wvalid_o <= 1'b0;
              outport_bready_o <= 1'b1;
              state            <= ST_WR_RESP;
            end else begin
              beat_cnt        <= beat_next;
              outport_wdata_o <= w_next_data;
              outport_wlast_o <= (beat_next == LEN);
            end
          end
        end
        ST_WR_RESP: begin
          if (b_hs) begin
            outport_bready_o <= 1'b0;
            if (last_burst) begin
              addr              <= ADDR_BASE;
              burst_cnt         <= '0;
              outport_arvalid_o <= 1'b1;
              outport_araddr_o  <= ADDR_BASE;
              outport_arid_o    <= AXI_ID;
              outport_arlen_o   <= LEN;
              outport_arburst_o <= 2'b01;
              state             <= ST_RD_ADDR;
            end else begin
              addr              <= addr + STRIDE;
              burst_cnt         <= burst_cnt + 16'd1;
              outport_awvalid_o <= 1'b1;
              outport_awaddr_o  <= addr + STRIDE;
              state             <= ST_WR_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (outport_arready_i) begin
            outport_arvalid_o <= 1'b0;
            outport_rready_o  <= 1'b1;
            beat_cnt          <= '0;
            state             <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (r_hs) begin
            if (beat_cnt == LEN) begin
              outport_rready_o <= 1'b0;
              if (last_burst) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= (err_next == 16'd0);
                state  <= ST_DONE;
              end else begin
                addr              <= addr + STRIDE;
                burst_cnt         <= burst_cnt + 16'd1;
                outport_arvalid_o <= 1'b1;
                outport_araddr_o  <= addr + STRIDE;
                state             <= ST_RD_ADDR;
              end
            end else begin
              beat_cnt <= beat_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_axi_traffic_gen.sv
// Directed bench for ddr3_axi_traffic_gen with a small reactive AXI slave
// (ideal, stalling, and error-injecting modes) and hand-derived expectations.
module tb_ddr3_axi_traffic_gen;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] SEED = 32'hA5A5_0000;
  localparam int unsigned NB   = 2;
  localparam int unsigned BL   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy_o, done_o, pass_o;
  logic [15:0] err_count_o;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  awid, arid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [3:0]  bid = 4'h0, rid = 4'h0;
  logic [31:0] rdata = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // slave configuration, written only by the stimulus process
  logic stall_en = 1'b0, corrupt_en = 1'b0, bresp_err_en = 1'b0, drop_rlast_en = 1'b0;

  ddr3_axi_traffic_gen #(
    .ADDR_BASE (BASE),
    .NUM_BURSTS(NB),
    .BURST_LEN (BL),
    .AXI_ID    (4'h3),
    .SEED      (SEED)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .err_count_o      (err_count_o),
    .outport_awvalid_o(awvalid),
    .outport_awaddr_o (awaddr),
    .outport_awid_o   (awid),
    .outport_awlen_o  (awlen),
    .outport_awburst_o(awburst),
    .outport_wvalid_o (wvalid),
    .outport_wdata_o  (wdata),
    .outport_wstrb_o  (wstrb),
    .outport_wlast_o  (wlast),
    .outport_bready_o (bready),
    .outport_arvalid_o(arvalid),
    .outport_araddr_o (araddr),
    .outport_arid_o   (arid),
    .outport_arlen_o  (arlen),
    .outport_arburst_o(arburst),
    .outport_rready_o (rready),
    .outport_awready_i(awready),
    .outport_wready_i (wready),
    .outport_arready_i(arready),
    .outport_bvalid_i (bvalid),
    .outport_bresp_i  (bresp),
    .outport_bid_i    (bid),
    .outport_rvalid_i (rvalid),
    .outport_rdata_i  (rdata),
    .outport_rresp_i  (rresp),
    .outport_rid_i    (rid),
    .outport_rlast_i  (rlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // slave state
  logic [31:0] mem [0:63];
  int unsigned aw_n, w_n, b_n, ar_n, r_n, rb_n, r_beat;
  int unsigned aw_st, w_st, ar_st;
  logic [31:0] r_addr, wa, first_wdata, last_wdata;
  logic        r_act, b_pend;
  logic        aw_v_s, aw_r_s, w_v_s, w_r_s, ar_v_s, ar_r_s, b_hs_s, r_hs_s;
  logic [45:0] aw_p_s, ar_p_s;
  logic [36:0] w_p_s;

  // Slave runs on the falling edge: first retires handshakes sampled at the
  // previous falling edge (they completed at the rising edge in between),
  // then drives new responses and samples the upcoming handshakes.
  always @(negedge clk) begin
    if (rst) begin
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; rb_n = 0; r_beat = 0;
      aw_st = 0; w_st = 0; ar_st = 0;
      r_act = 1'b0; b_pend = 1'b0; r_addr = '0;
      aw_v_s = 1'b0; aw_r_s = 1'b0; w_v_s = 1'b0; w_r_s = 1'b0;
      ar_v_s = 1'b0; ar_r_s = 1'b0; b_hs_s = 1'b0; r_hs_s = 1'b0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    end else begin
      if (aw_v_s) begin
        if (aw_r_s) begin
          check("aw_beat", {18'b0, aw_p_s}, {18'b0, 4'h3, 8'd3, 2'b01, BASE + 32'(aw_n * 16)});
          aw_n++;
          if (stall_en) aw_st = $urandom_range(0, 5);
        end else
          check("aw_hold", {17'b0, awvalid, awid, awlen, awburst, awaddr}, {17'b0, 1'b1, aw_p_s});
      end
      if (w_v_s) begin
        if (w_r_s) begin
          wa = BASE + 32'(w_n * 4);
          check("w_beat", {27'b0, w_p_s}, {27'b0, (w_n % 4) == 3, 4'hF, wa ^ SEED});
          mem[wa[7:2]] = w_p_s[31:0];
          if (w_n == 0) first_wdata = w_p_s[31:0];
          last_wdata = w_p_s[31:0];
          if (w_p_s[36]) b_pend = 1'b1;
          w_n++;
          if (stall_en) w_st = $urandom_range(0, 5);
        end else
          check("w_hold", {26'b0, wvalid, wlast, wstrb, wdata}, {26'b0, 1'b1, w_p_s});
      end
      if (b_hs_s) begin
        b_pend = 1'b0;
        b_n++;
      end
      if (ar_v_s) begin
        if (ar_r_s) begin
          check("ar_beat", {18'b0, ar_p_s}, {18'b0, 4'h3, 8'd3, 2'b01, BASE + 32'(ar_n * 16)});
          r_addr = ar_p_s[31:0];
          r_beat = 0;
          r_act  = 1'b1;
          ar_n++;
          if (stall_en) ar_st = $urandom_range(0, 5);
        end else
          check("ar_hold", {17'b0, arvalid, arid, arlen, arburst, araddr}, {17'b0, 1'b1, ar_p_s});
      end
      if (r_hs_s) begin
        r_n++;
        if (r_beat == BL) begin
          r_act = 1'b0;
          if (rb_n == NB - 1) check("done_latency", {62'b0, busy_o, done_o}, 64'h1);
          rb_n++;
        end else begin
          r_beat++;
          r_addr = r_addr + 32'd4;
        end
      end

      awready = !stall_en || (aw_st == 0);
      wready  = !stall_en || (w_st == 0);
      arready = !stall_en || (ar_st == 0);
      if (stall_en && aw_st > 0) aw_st--;
      if (stall_en && w_st > 0) w_st--;
      if (stall_en && ar_st > 0) ar_st--;
      bvalid = b_pend;
      bresp  = (bresp_err_en && b_n == 0) ? 2'b10 : 2'b00;
      bid    = 4'h3;
      rvalid = r_act;
      rdata  = mem[r_addr[7:2]] ^ ((corrupt_en && r_addr == 32'h0000_1014) ? 32'h1 : 32'h0);
      rresp  = 2'b00;
      rid    = 4'h3;
      rlast  = r_act && (r_beat == BL) && !(drop_rlast_en && rb_n == 0);

      aw_v_s = awvalid; aw_r_s = awready; aw_p_s = {awid, awlen, awburst, awaddr};
      w_v_s  = wvalid;  w_r_s  = wready;  w_p_s  = {wlast, wstrb, wdata};
      ar_v_s = arvalid; ar_r_s = arready; ar_p_s = {arid, arlen, arburst, araddr};
      b_hs_s = bvalid && bready;
      r_hs_s = rvalid && rready;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_pass(input bit check_launch);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (check_launch)
      check("launch", {30'b0, busy_o, awvalid, awaddr}, {30'b0, 1'b1, 1'b1, BASE});
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (done_o) break;
      tick();
    end
    check(tag, {63'b0, done_o}, 64'h1);
  endtask

  task automatic check_result(input string tag, input logic exp_pass, input logic [15:0] exp_err);
    check({tag, "_status"}, {61'b0, busy_o, done_o, pass_o}, {61'b0, 1'b0, 1'b1, exp_pass});
    check({tag, "_err"}, {48'b0, err_count_o}, {48'b0, exp_err});
    check({tag, "_beats"}, {44'(aw_n), 4'(b_n), 8'(w_n), 8'(r_n)}, {44'd2, 4'd2, 8'd8, 8'd8});
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_status", {48'b0, busy_o, done_o, pass_o, err_count_o}, 64'h0);
    check("rst_valids", {59'b0, awvalid, wvalid, arvalid, bready, rready}, 64'h0);
    check("rst_payload", {awaddr, wdata}, 64'h0);
    check("rst_araddr", {32'b0, araddr}, 64'h0);

    // ideal slave
    start_pass(1'b1);
    wait_done("ideal_done");
    check_result("ideal", 1'b1, 16'd0);
    check("first_wdata", {32'b0, first_wdata}, {32'b0, 32'hA5A5_1000});
    check("last_wdata", {32'b0, last_wdata}, {32'b0, 32'hA5A5_101C});

    // single corrupted read beat
    do_reset();
    corrupt_en = 1'b1;
    start_pass(1'b1);
    wait_done("corrupt_done");
    check_result("corrupt", 1'b0, 16'd1);
    corrupt_en = 1'b0;

    // bad bresp on first B plus missing rlast on first read burst
    do_reset();
    bresp_err_en = 1'b1;
    drop_rlast_en = 1'b1;
    start_pass(1'b1);
    wait_done("bresp_done");
    check_result("bresp_rlast", 1'b0, 16'd2);
    bresp_err_en = 1'b0;
    drop_rlast_en = 1'b0;

    // random ready stalls
    do_reset();
    stall_en = 1'b1;
    start_pass(1'b1);
    wait_done("stall_done");
    check_result("stall", 1'b1, 16'd0);
    stall_en = 1'b0;

    // reset in WR_DATA at beat 2, then restart
    do_reset();
    start_pass(1'b1);
    for (int i = 0; i < 200; i++) begin
      if (w_n == 2) break;
      tick();
    end
    check("reach_beat2", {32'b0, w_n}, 64'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valids", {58'b0, awvalid, wvalid, arvalid, bready, rready, busy_o}, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    start_pass(1'b1);
    wait_done("restart_done");
    check_result("restart", 1'b1, 16'd0);

    // start while busy is ignored
    do_reset();
    start_pass(1'b1);
    for (int i = 0; i < 200; i++) begin
      if (ar_n >= 1) break;
      tick();
    end
    start_pass(1'b0);
    check("busy_start", {62'b0, busy_o, awvalid}, 64'h2);
    wait_done("busy_start_done");
    check_result("busy_start", 1'b1, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
